freq_gate_sequencer: RTL and testbench

//  Measurement sequencer for the frequency meter datapath. It replaces the fixed 1 s gate with

---
 rtl/freq_gate_sequencer.sv | 150 +++++++++++++++
 tb/tb_freq_gate_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_sequencer.sv
// Measurement sequencer for the frequency meter: clear -> gate -> latch -> hold cycle
// with selectable 10 ms .. 10 s gate times and optional autoranging.
module freq_gate_sequencer #(
    parameter int unsigned TICKS_BASE = 10_000,
    parameter int unsigned HOLD_TICKS = 200_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic       fpga_clk,
    input  logic       nreset,
    input  logic       tick_1us,
    input  logic       run,
    input  logic       auto_range,
    input  logic [1:0] range_sel,
    input  logic       ovf_in,
    input  logic       msd_zero,
    output logic       gate_open,
    output logic       clear_ctr,
    output logic       latch_pulse,
    output logic       meas_done,
    output logic [1:0] range_q,
    output logic       overrange,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARM   = 3'd2,
        GATE  = 3'd3,
        LATCH = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST0     = CNT_W'(TICKS_BASE - 1);
    localparam logic [CNT_W-1:0] LAST1     = CNT_W'(TICKS_BASE * 10 - 1);
    localparam logic [CNT_W-1:0] LAST2     = CNT_W'(TICKS_BASE * 100 - 1);
    localparam logic [CNT_W-1:0] LAST3     = CNT_W'(TICKS_BASE * 1000 - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

    state_t           state_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [1:0]       cur_range_q;
    logic             ovf_seen_q;
    logic             auto_mode_q;
    logic [CNT_W-1:0] gate_last;

    always_comb begin
        gate_last = LAST0;
        unique case (cur_range_q)
            2'd0: gate_last = LAST0;
            2'd1: gate_last = LAST1;
            2'd2: gate_last = LAST2;
            2'd3: gate_last = LAST3;
            default: gate_last = LAST0;
        endcase
    end

    // auto_range is captured at CLEAR so mid-measurement changes wait for the next cycle
    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            cur_range_q <= 2'd2;
            ovf_seen_q  <= 1'b0;
            auto_mode_q <= 1'b0;
            gate_open   <= 1'b0;
            clear_ctr   <= 1'b0;
            latch_pulse <= 1'b0;
            meas_done   <= 1'b0;
            range_q     <= 2'd2;
            overrange   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            clear_ctr   <= 1'b0;
            latch_pulse <= 1'b0;
            meas_done   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q   <= CLEAR;
                        clear_ctr <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    ovf_seen_q  <= 1'b0;
                    auto_mode_q <= auto_range;
                    if (!auto_range) cur_range_q <= range_sel;
                    state_q <= ARM;
                end
                ARM: begin
                    if (tick_1us) begin
                        state_q    <= GATE;
                        tick_cnt_q <= '0;
                        gate_open  <= 1'b1;
                    end
                end
                GATE: begin
                    if (ovf_in && auto_mode_q && (cur_range_q != 2'd0)) begin
                        cur_range_q <= cur_range_q - 2'd1;
                        state_q     <= CLEAR;
                        clear_ctr   <= 1'b1;
                        gate_open   <= 1'b0;
                    end else begin
                        if (ovf_in) ovf_seen_q <= 1'b1;
                        if (tick_1us) begin
                            if (tick_cnt_q == gate_last) begin
                                state_q     <= LATCH;
                                gate_open   <= 1'b0;
                                latch_pulse <= 1'b1;
                                meas_done   <= 1'b1;
                            end else begin
                                tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    range_q   <= cur_range_q;
                    overrange <= ovf_seen_q;
                    if (auto_mode_q && msd_zero && !ovf_seen_q && (cur_range_q != 2'd3))
                        cur_range_q <= cur_range_q + 2'd1;
                    state_q    <= HOLD;
                    tick_cnt_q <= '0;
                end
                HOLD: begin
                    if (tick_1us) begin
                        if (tick_cnt_q == HOLD_LAST) begin
                            if (run) begin
                                state_q   <= CLEAR;
                                clear_ctr <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gate_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Directed bench for freq_gate_sequencer: table of measurements plus hand-written
// sequences for overflow retry, overflow on the final tick, stop-after-hold and reset.
module tb_freq_gate_sequencer;

    logic       fpga_clk = 1'b0;
    logic       nreset   = 1'b0;
    logic       tick_1us = 1'b0;
    logic       run = 1'b0, auto_range = 1'b0, ovf_in = 1'b0, msd_zero = 1'b0;
    logic [1:0] range_sel = 2'd0;
    logic       gate_open, clear_ctr, latch_pulse, meas_done, overrange, busy;
    logic [1:0] range_q;

    int passed = 0;
    int total  = 0;
    int div    = 4;
    int tcnt   = 0;

    freq_gate_sequencer #(.TICKS_BASE(10), .HOLD_TICKS(5), .CNT_W(24)) dut (
        .fpga_clk(fpga_clk), .nreset(nreset), .tick_1us(tick_1us), .run(run),
        .auto_range(auto_range), .range_sel(range_sel), .ovf_in(ovf_in),
        .msd_zero(msd_zero), .gate_open(gate_open), .clear_ctr(clear_ctr),
        .latch_pulse(latch_pulse), .meas_done(meas_done), .range_q(range_q),
        .overrange(overrange), .busy(busy)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Timebase model: one-clock tick every div clocks (div=1 -> every clock)
    always @(posedge fpga_clk) begin
        if (tcnt >= div - 1) begin
            tcnt     <= 0;
            tick_1us <= 1'b1;
        end else begin
            tcnt     <= tcnt + 1;
            tick_1us <= 1'b0;
        end
    end

    typedef struct {
        string      nm;
        logic       run;
        logic       auto_r;
        logic [1:0] rsel;
        logic       msd;
        int         div;
        int         gate;
        int         rng;
        int         ovr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_clear(input string nm);
        int w = 0;
        while (!clear_ctr && w < 60000) begin
            @(negedge fpga_clk);
            w++;
        end
        chk({nm, "_clear_seen"}, int'(clear_ctr), 1);
        @(negedge fpga_clk);
        chk({nm, "_clear_width"}, int'(clear_ctr), 0);
    endtask

    task automatic gate_and_latch(input string nm, input int exp_gate, input int exp_rng,
                                  input int exp_ovr, input int chg_at, input int chg_rsel,
                                  input int chg_run, input int ovf_tick);
        int w = 0;
        int n = 0;
        int tk = 0;
        while (!gate_open && w < 200) begin
            @(negedge fpga_clk);
            w++;
        end
        chk({nm, "_gate_rise"}, int'(gate_open), 1);
        while (gate_open && n < 60000) begin
            n++;
            if (tick_1us) tk++;
            ovf_in = (tk == ovf_tick) && tick_1us;
            if (n == chg_at) begin
                range_sel = chg_rsel[1:0];
                run       = chg_run[0];
            end
            @(negedge fpga_clk);
        end
        ovf_in = 1'b0;
        chk({nm, "_gate_len"}, n, exp_gate);
        chk({nm, "_latch_done"}, int'({latch_pulse, meas_done}), 3);
        chk({nm, "_no_clr_at_latch"}, int'(clear_ctr), 0);
        @(negedge fpga_clk);
        chk({nm, "_range"}, int'(range_q), exp_rng);
        chk({nm, "_ovr"}, int'(overrange), exp_ovr);
        chk({nm, "_latch_1cyc"}, int'(latch_pulse), 0);
    endtask

    task automatic measure(input string nm, input int exp_gate, input int exp_rng,
                           input int exp_ovr, input int ovf_tick);
        wait_clear(nm);
        gate_and_latch(nm, exp_gate, exp_rng, exp_ovr, -1, 0, 1, ovf_tick);
    endtask

    initial begin
        int w;
        int tk;
        int k;
        int clr;

        vecs[0] = '{"m_r0",     1'b1, 1'b0, 2'd0, 1'b0, 4, 40,    0, 0};
        vecs[1] = '{"m_r1",     1'b1, 1'b0, 2'd1, 1'b0, 4, 400,   1, 0};
        vecs[2] = '{"m_nostep", 1'b1, 1'b0, 2'd0, 1'b1, 1, 10,    0, 0};
        vecs[3] = '{"a_r0",     1'b1, 1'b1, 2'd3, 1'b1, 1, 10,    0, 0};
        vecs[4] = '{"a_r1",     1'b1, 1'b1, 2'd3, 1'b1, 1, 100,   1, 0};
        vecs[5] = '{"a_r2",     1'b1, 1'b1, 2'd3, 1'b1, 1, 1000,  2, 0};
        vecs[6] = '{"a_r3",     1'b1, 1'b1, 2'd3, 1'b1, 1, 10000, 3, 0};
        vecs[7] = '{"a_r3sat",  1'b1, 1'b1, 2'd3, 1'b1, 1, 10000, 3, 0};

        repeat (3) @(negedge fpga_clk);
        chk("rst_gate", int'(gate_open), 0);
        chk("rst_ctl", int'({clear_ctr, latch_pulse, meas_done, overrange, busy}), 0);
        chk("rst_range", int'(range_q), 2);
        nreset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run        = vecs[i].run;
            auto_range = vecs[i].auto_r;
            range_sel  = vecs[i].rsel;
            msd_zero   = vecs[i].msd;
            div        = vecs[i].div;
            measure(vecs[i].nm, vecs[i].gate, vecs[i].rng, vecs[i].ovr, -1);
        end

        // range_sel changed mid-gate only applies from the next CLEAR
        auto_range = 1'b0;
        msd_zero   = 1'b0;
        range_sel  = 2'd3;
        wait_clear("sel_mid");
        gate_and_latch("sel_mid", 10000, 3, 0, 100, 0, 1, -1);
        measure("sel_next", 10, 0, 0, -1);

        // autorange retry on overflow from range 2
        range_sel = 2'd2;
        measure("pre_retry", 1000, 2, 0, -1);
        auto_range = 1'b1;
        wait_clear("retry");
        w = 0;
        while (!gate_open && w < 200) begin
            @(negedge fpga_clk);
            w++;
        end
        repeat (5) @(negedge fpga_clk);
        ovf_in = 1'b1;
        @(negedge fpga_clk);
        ovf_in = 1'b0;
        chk("retry_gate_closed", int'(gate_open), 0);
        chk("retry_clear", int'(clear_ctr), 1);
        chk("retry_no_latch", int'({latch_pulse, meas_done}), 0);
        chk("retry_range_kept", int'(range_q), 2);
        gate_and_latch("retry_new", 100, 1, 0, -1, 0, 1, -1);

        // manual overflow on the final tick: latched with overrange, then cleared
        auto_range = 1'b0;
        range_sel  = 2'd0;
        div        = 4;
        measure("ovf_last", 40, 0, 1, 10);
        measure("ovf_clean", 40, 0, 0, -1);

        // run dropped mid-gate: measurement completes, 5-tick hold, then idle
        wait_clear("stop");
        gate_and_latch("stop", 40, 0, 0, 5, 0, 0, -1);
        tk = 0;
        k = 0;
        clr = 0;
        while (busy && k < 100) begin
            if (tick_1us) tk++;
            if (clear_ctr) clr++;
            @(negedge fpga_clk);
            k++;
        end
        chk("stop_idle", int'(busy), 0);
        chk("stop_hold_ticks", tk, 5);
        repeat (20) begin
            if (clear_ctr) clr++;
            @(negedge fpga_clk);
        end
        chk("stop_no_restart", clr, 0);
        chk("stop_busy_low", int'(busy), 0);

        // asynchronous reset in the middle of a gate
        run = 1'b1;
        wait_clear("rst_mid");
        w = 0;
        while (!gate_open && w < 200) begin
            @(negedge fpga_clk);
            w++;
        end
        chk("rst_mid_gate_open", int'(gate_open), 1);
        repeat (3) @(negedge fpga_clk);
        nreset = 1'b0;
        #1;
        chk("rst_mid_gate", int'(gate_open), 0);
        chk("rst_mid_range", int'(range_q), 2);
        chk("rst_mid_busy", int'(busy), 0);
        repeat (2) @(negedge fpga_clk);
        nreset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
